// File: rtl/mips_cpu_mem_arbiter.sv
// Purpose : shares one wait-stated memory bus between the instruction-fetch and data ports, round-robin.
// Latency : command one cycle after the request, *_valid one cycle after the first non-stalled bus cycle.
// Backpress: mem_waitrequest freezes the registered bus command; a watchdog aborts after TIMEOUT waits.
//
// Ports:
//   clk, reset                       - single clock, synchronous active-high reset
//   instr_req/instr_address          - fetch request (held until instr_valid)
//   instr_readdata/instr_valid       - registered fetch result, one-cycle completion pulse
//   data_read/data_write/data_*      - data request (held until data_valid); read+write means write
//   data_readdata/data_valid         - registered read result, one-cycle completion pulse
//   mem_*                            - unified memory bus, driven only from registers
//   bus_error                        - one-cycle pulse alongside *_valid when the watchdog aborts
//   grant_data                       - high while the data port owns the bus
module mips_cpu_mem_arbiter #(
   parameter int TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        instr_req,
   input  logic [31:0] instr_address,
   output logic [31:0] instr_readdata,
   output logic        instr_valid,
   input  logic        data_read,
   input  logic        data_write,
   input  logic [31:0] data_address,
   input  logic [31:0] data_writedata,
   input  logic [3:0]  data_byteenable,
   output logic [31:0] data_readdata,
   output logic        data_valid,
   output logic [31:0] mem_address,
   output logic        mem_read,
   output logic        mem_write,
   output logic [31:0] mem_writedata,
   output logic [3:0]  mem_byteenable,
   input  logic [31:0] mem_readdata,
   input  logic        mem_waitrequest,
   output logic        bus_error,
   output logic        grant_data
);

   localparam int CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
   localparam logic [CW-1:0] WD_LAST = CW'(TIMEOUT - 1);
   localparam bit WD_EN = (TIMEOUT != 0);

   typedef enum logic [1:0] {IDLE, BUS_I, BUS_D} state_t;

   state_t        state, state_nxt;
   logic          last_grant;   // 0: instr served last, 1: data served last
   logic [CW-1:0] wait_cnt;

   logic d_pend, i_pend, grant_d, grant_i, done, abort;

   always_comb begin
      state_nxt = state;
      // A port currently showing its valid pulse is still holding its old
      // request; it must not be re-granted on that stale request.
      d_pend  = (data_read | data_write) & ~data_valid;
      i_pend  = instr_req & ~instr_valid;
      grant_d = 1'b0;
      grant_i = 1'b0;
      done    = 1'b0;
      abort   = 1'b0;
      case (state)
         IDLE: begin
            grant_d = d_pend & (~i_pend | ~last_grant);
            grant_i = i_pend & ~grant_d;
            if (grant_d)      state_nxt = BUS_D;
            else if (grant_i) state_nxt = BUS_I;
         end
         BUS_I, BUS_D: begin
            done  = ~mem_waitrequest;
            abort = WD_EN & mem_waitrequest & (wait_cnt == WD_LAST);
            if (done || abort) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         mem_address    <= '0;
         mem_read       <= 1'b0;
         mem_write      <= 1'b0;
         mem_writedata  <= '0;
         mem_byteenable <= '0;
         instr_readdata <= '0;
         data_readdata  <= '0;
         instr_valid    <= 1'b0;
         data_valid     <= 1'b0;
         bus_error      <= 1'b0;
         last_grant     <= 1'b0;
         wait_cnt       <= '0;
      end else begin
         instr_valid <= 1'b0;
         data_valid  <= 1'b0;
         bus_error   <= 1'b0;
         if (grant_d) begin
            mem_address    <= data_address;
            mem_writedata  <= data_writedata;
            mem_byteenable <= data_byteenable;
            mem_write      <= data_write;
            mem_read       <= ~data_write;
            wait_cnt       <= '0;
         end else if (grant_i) begin
            mem_address    <= instr_address;
            mem_writedata  <= '0;
            mem_byteenable <= 4'hF;
            mem_write      <= 1'b0;
            mem_read       <= 1'b1;
            wait_cnt       <= '0;
         end else if (done || abort) begin
            if (state == BUS_D) begin
               data_valid <= 1'b1;
               if (abort)         data_readdata <= '0;
               else if (mem_read) data_readdata <= mem_readdata;
            end else begin
               instr_valid <= 1'b1;
               instr_readdata <= abort ? '0 : mem_readdata;
            end
            bus_error      <= abort;
            last_grant     <= (state == BUS_D);
            mem_address    <= '0;
            mem_read       <= 1'b0;
            mem_write      <= 1'b0;
            mem_writedata  <= '0;
            mem_byteenable <= '0;
         end else if (state != IDLE && wait_cnt != '1) begin
            // Saturates so a disabled watchdog never wraps.
            wait_cnt <= wait_cnt + CW'(1);
         end
      end
   end

   assign grant_data = (state == BUS_D);

endmodule

// File: tb/tb_mips_cpu_mem_arbiter.sv
// Purpose : directed bench for mips_cpu_mem_arbiter with a transaction-level reference model.
// Latency : model predicts every output each cycle; directed steps pin literal values.
// Backpress: bench drives mem_waitrequest directly to exercise stalls and the watchdog.
module tb_mips_cpu_mem_arbiter;
   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        instr_req;
   logic [31:0] instr_address;
   logic [31:0] instr_readdata;
   logic        instr_valid;
   logic        data_read, data_write;
   logic [31:0] data_address, data_writedata;
   logic [3:0]  data_byteenable;
   logic [31:0] data_readdata;
   logic        data_valid;
   logic [31:0] mem_address;
   logic        mem_read, mem_write;
   logic [31:0] mem_writedata;
   logic [3:0]  mem_byteenable;
   logic [31:0] mem_readdata;
   logic        mem_waitrequest;
   logic        bus_error;
   logic        grant_data;

   int vectors = 0;
   int miscompares = 0;

   mips_cpu_mem_arbiter #(.TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset),
      .instr_req(instr_req), .instr_address(instr_address),
      .instr_readdata(instr_readdata), .instr_valid(instr_valid),
      .data_read(data_read), .data_write(data_write), .data_address(data_address),
      .data_writedata(data_writedata), .data_byteenable(data_byteenable),
      .data_readdata(data_readdata), .data_valid(data_valid),
      .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
      .mem_writedata(mem_writedata), .mem_byteenable(mem_byteenable),
      .mem_readdata(mem_readdata), .mem_waitrequest(mem_waitrequest),
      .bus_error(bus_error), .grant_data(grant_data)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: who owns the bus (0 none, 1 instr, 2 data), the
   // transaction being carried, and what each port last received.
   int          m_owner, m_waited, m_last;
   logic [31:0] m_addr, m_wd, m_ird, m_drd;
   logic [3:0]  m_be;
   logic        m_rd, m_wr, m_iv, m_dv, m_err;
   bit          m_ok = 0;

   always @(posedge clk) begin : model
      int          own, wt, last, pick;
      logic [31:0] a, wd, ird, drd;
      logic [3:0]  be;
      logic        rd, wr, iv, dv, err;
      bit          dp, ip;
      if (reset) begin
         m_owner <= 0; m_waited <= 0; m_last <= 1;
         m_addr <= '0; m_wd <= '0; m_be <= '0; m_rd <= 1'b0; m_wr <= 1'b0;
         m_ird <= '0; m_drd <= '0; m_iv <= 1'b0; m_dv <= 1'b0; m_err <= 1'b0;
         m_ok <= 1;
      end else begin
         own = m_owner; wt = m_waited; last = m_last;
         a = m_addr; wd = m_wd; be = m_be; rd = m_rd; wr = m_wr;
         ird = m_ird; drd = m_drd;
         iv = 1'b0; dv = 1'b0; err = 1'b0;
         if (own == 0) begin
            dp = (data_read || data_write) && !m_dv;
            ip = instr_req && !m_iv;
            if (dp && ip) pick = (m_last == 1) ? 2 : 1;
            else          pick = dp ? 2 : (ip ? 1 : 0);
            if (pick == 2) begin
               a = data_address; wd = data_writedata; be = data_byteenable;
               wr = data_write; rd = !data_write; wt = 0;
            end else if (pick == 1) begin
               a = instr_address; wd = '0; be = 4'hF; wr = 1'b0; rd = 1'b1; wt = 0;
            end
            own = pick;
         end else begin
            if (!mem_waitrequest || wt + 1 >= TO) begin
               err = mem_waitrequest;
               if (own == 1) begin
                  iv = 1'b1; ird = err ? 32'h0 : mem_readdata;
               end else begin
                  dv = 1'b1;
                  if (err)     drd = 32'h0;
                  else if (rd) drd = mem_readdata;
               end
               last = own; own = 0;
               a = '0; wd = '0; be = '0; rd = 1'b0; wr = 1'b0;
            end else begin
               wt = wt + 1;
            end
         end
         m_owner <= own; m_waited <= wt; m_last <= last;
         m_addr <= a; m_wd <= wd; m_be <= be; m_rd <= rd; m_wr <= wr;
         m_ird <= ird; m_drd <= drd; m_iv <= iv; m_dv <= dv; m_err <= err;
      end
   end

   always @(negedge clk) begin
      if (m_ok) begin
         chk("mem_address", mem_address, m_addr);
         chk("mem_read", mem_read, m_rd);
         chk("mem_write", mem_write, m_wr);
         chk("mem_writedata", mem_writedata, m_wd);
         chk("mem_byteenable", mem_byteenable, m_be);
         chk("instr_readdata", instr_readdata, m_ird);
         chk("instr_valid", instr_valid, m_iv);
         chk("data_readdata", data_readdata, m_drd);
         chk("data_valid", data_valid, m_dv);
         chk("bus_error", bus_error, m_err);
         chk("grant_data", grant_data, m_owner == 2);
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   initial begin
      reset = 1'b1; instr_req = 1'b0; instr_address = '0;
      data_read = 1'b0; data_write = 1'b0; data_address = '0;
      data_writedata = '0; data_byteenable = '0;
      mem_readdata = '0; mem_waitrequest = 1'b0;
      tick(); tick();
      chk("reset_mem_read", mem_read, 1'b0);
      chk("reset_grant_data", grant_data, 1'b0);
      chk("reset_data_readdata", data_readdata, 32'h0);
      reset = 1'b0;
      tick();

      // Contention straight after reset: data first, then instr, then data again.
      instr_req = 1'b1; instr_address = 32'h400;
      data_read = 1'b1; data_address = 32'h2000; mem_readdata = 32'hCAFEF00D;
      tick();
      chk("rr1_grant_data", grant_data, 1'b1);
      chk("rr1_addr", mem_address, 32'h2000);
      tick();
      chk("rr1_dvalid", data_valid, 1'b1);
      chk("rr1_drd", data_readdata, 32'hCAFEF00D);
      data_read = 1'b0; mem_readdata = 32'h12345678;
      tick();
      chk("rr2_addr", mem_address, 32'h400);
      chk("rr2_be", mem_byteenable, 4'hF);
      tick();
      chk("rr2_ivalid", instr_valid, 1'b1);
      chk("rr2_ird", instr_readdata, 32'h12345678);
      instr_req = 1'b0;
      tick();
      instr_req = 1'b1; data_read = 1'b1; data_address = 32'h2004;
      mem_readdata = 32'h0BADF00D;
      tick();
      chk("rr3_grant_data", grant_data, 1'b1);
      chk("rr3_addr", mem_address, 32'h2004);
      tick();
      chk("rr3_drd", data_readdata, 32'h0BADF00D);
      data_read = 1'b0; mem_readdata = 32'h55AA55AA;
      tick();
      chk("rr4_grant_instr", mem_address, 32'h400);
      tick();
      chk("rr4_ird", instr_readdata, 32'h55AA55AA);
      instr_req = 1'b0;
      tick();

      // Single zero-wait fetch.
      instr_req = 1'b1; instr_address = 32'hBFC00000; mem_readdata = 32'h24020005;
      tick();
      chk("fetch_mem_read", mem_read, 1'b1);
      chk("fetch_addr", mem_address, 32'hBFC00000);
      tick();
      chk("fetch_valid", instr_valid, 1'b1);
      chk("fetch_data", instr_readdata, 32'h24020005);
      instr_req = 1'b0;
      tick();
      chk("fetch_idle", mem_read, 1'b0);

      // Data write stalled for three wait cycles.
      data_write = 1'b1; data_address = 32'h1000; data_writedata = 32'hDEADBEEF;
      data_byteenable = 4'b0011; mem_waitrequest = 1'b1;
      tick();
      for (int i = 1; i <= 4; i++) begin
         chk("wr_stable_write", mem_write, 1'b1);
         chk("wr_stable_addr", mem_address, 32'h1000);
         chk("wr_stable_wd", mem_writedata, 32'hDEADBEEF);
         chk("wr_stable_be", mem_byteenable, 4'b0011);
         chk("wr_no_early_valid", data_valid, 1'b0);
         if (i == 4) mem_waitrequest = 1'b0;
         tick();
      end
      chk("wr_valid", data_valid, 1'b1);
      chk("wr_drd_kept", data_readdata, 32'h0BADF00D);
      data_write = 1'b0;
      tick();
      chk("wr_single_pulse", data_valid, 1'b0);

      // Read and write together behave as a write.
      data_read = 1'b1; data_write = 1'b1; data_address = 32'h1004;
      data_writedata = 32'h01020304; data_byteenable = 4'hF;
      tick();
      chk("rw_write", mem_write, 1'b1);
      chk("rw_no_read", mem_read, 1'b0);
      tick();
      chk("rw_valid", data_valid, 1'b1);
      data_read = 1'b0; data_write = 1'b0;
      tick();

      // Watchdog abort after TO wait cycles.
      data_read = 1'b1; data_address = 32'h3000; mem_waitrequest = 1'b1;
      tick();
      for (int i = 1; i <= TO; i++) begin
         chk("wd_busy", grant_data, 1'b1);
         chk("wd_no_err", bus_error, 1'b0);
         tick();
      end
      chk("wd_err", bus_error, 1'b1);
      chk("wd_valid", data_valid, 1'b1);
      chk("wd_drd_zero", data_readdata, 32'h0);
      chk("wd_idle", grant_data, 1'b0);
      data_read = 1'b0; mem_waitrequest = 1'b0;
      tick();

      // Reset while a stalled data write owns the bus.
      data_write = 1'b1; data_address = 32'h4000; data_writedata = 32'h77;
      data_byteenable = 4'hF; mem_waitrequest = 1'b1;
      tick();
      chk("rst_mid_busy", grant_data, 1'b1);
      reset = 1'b1; data_write = 1'b0;
      tick();
      chk("rst_mid_write", mem_write, 1'b0);
      chk("rst_mid_addr", mem_address, 32'h0);
      reset = 1'b0; mem_waitrequest = 1'b0;
      tick();
      chk("rst_mid_no_valid", data_valid, 1'b0);
      instr_req = 1'b1; instr_address = 32'h80000000; mem_readdata = 32'h8C080000;
      tick();
      chk("rst_fetch_cmd", mem_read, 1'b1);
      tick();
      chk("rst_fetch_valid", instr_valid, 1'b1);
      chk("rst_fetch_data", instr_readdata, 32'h8C080000);
      instr_req = 1'b0;
      tick(); tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/mips_cpu_mem_arbiter.md
# mips_cpu_mem_arbiter

Sequencing arbiter that shares one single-ported, wait-stated memory bus between the CPU's instruction-fetch port and data port. It sits between the Harvard core's `instr_*`/`data_*` interface and a unified memory, so the core can run on a von Neumann memory system. It grants one requester at a time with round-robin fairness, holds bus commands stable across `mem_waitrequest`, and returns read data with a one-cycle valid pulse. A watchdog aborts stuck transfers.

## Interface
Parameters:
- `TIMEOUT`, default 255: maximum wait cycles before abort; 0 disables the watchdog.

Ports. Clock is `clk`; reset is `reset`, synchronous and active-high.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `instr_req` in 1: fetch request; held until `instr_valid`.
- `instr_address` in 32: fetch address; stable while `instr_req` is high.
- `instr_readdata` out 32: fetched word, registered.
- `instr_valid` out 1: one-cycle completion pulse.
- `data_read` in 1: data read request; held until `data_valid`.
- `data_write` in 1: data write request; held until `data_valid`.
- `data_address` in 32: data address.
- `data_writedata` in 32: write data.
- `data_byteenable` in 4: byte lanes for data access.
- `data_readdata` out 32: read word, registered.
- `data_valid` out 1: one-cycle completion pulse, for reads and writes.
- `mem_address` out 32: bus address.
- `mem_read` out 1: bus read command.
- `mem_write` out 1: bus write command.
- `mem_writedata` out 32: bus write data.
- `mem_byteenable` out 4: bus byte enables.
- `mem_readdata` in 32: bus read data, valid in the cycle `mem_waitrequest` is 0.
- `mem_waitrequest` in 1: bus stall; the command is accepted and complete in the first cycle it is 0.
- `bus_error` out 1: one-cycle pulse on watchdog abort.
- `grant_data` out 1: 1 while the data port owns the bus (debug/stall use).

## Operation
- States:
  - IDLE: no command driven.
  - BUS_I: fetch in flight.
  - BUS_D: data transfer in flight.
- Request evaluation in IDLE:
  - `d_pend` = `data_read` | `data_write`.
  - `i_pend` = `instr_req`.
  - A port whose `*_valid` is high in the current cycle is treated as not pending.
- Grant rules in IDLE:
  - Only one port pending: grant it.
  - Both pending: grant the port not granted last (`last_grant` pointer).
  - Reset sets `last_grant` = instr, so the first contention goes to data.
- On the grant edge, capture the following into registers, and drive the bus from those registers only:
  - address
  - write data
  - byte enables (instr grant forces 4'hF)
  - command
- A data request with both `data_read` and `data_write` set is a write.
- In BUS_x, with `mem_waitrequest` = 0 at a rising edge:
  - Read: latch `mem_readdata` into the port's readdata register.
  - Write: leave `data_readdata` unchanged.
  - Pulse that port's `*_valid` for the next cycle.
  - Update `last_grant`.
  - Return to IDLE.
- In BUS_x, with `mem_waitrequest` = 1: hold every bus output unchanged and increment the wait counter (8+ bits, sized for `TIMEOUT`).
- Watchdog: if `TIMEOUT` != 0 and the wait counter reaches `TIMEOUT` while waitrequest is still 1:
  - Abort and drop the command.
  - Pulse `*_valid` and `bus_error` together.
  - Readdata = 32'h0.
  - Return to IDLE.
- Wait counter clears on every grant.
- `grant_data` = (state == BUS_D).

## Timing
- Reset values:
  - state IDLE
  - all `mem_*` outputs 0
  - `instr_readdata`/`data_readdata` 0
  - `instr_valid`/`data_valid`/`bus_error` 0
  - `grant_data` 0
  - wait counter 0
- Reset mid-transfer: the command drops the cycle after the reset edge; no valid pulse follows.
- Minimum latency, request at cycle 0 with zero-wait bus:
  - Command driven in cycle 1.
  - `*_valid` high in cycle 2.
  - Next grant issued on the cycle-2 edge, with its command in cycle 3.
- Each wait cycle adds 1 cycle of latency.
- The bus is idle for at least one cycle between transfers, so there are no back-to-back commands.
- A requester may re-assert in the cycle after its valid pulse. A request held through the valid cycle is ignored for that cycle only.
- Inputs are sampled only at grant; changes during BUS_x do not affect the in-flight transfer.
- Watchdog abort occurs on the edge ending the `TIMEOUT`-th wait cycle; valid and error follow one cycle later.

## Test plan
- Single fetch, zero-wait:
  - Stimulus: `instr_req`=1, addr 0xBFC00000, `mem_readdata`=0x24020005.
  - Response: `mem_read`=1 with address 0xBFC00000 in cycle 1; `instr_valid`=1 and `instr_readdata`=0x24020005 in cycle 2.
- Data write with 3 wait cycles:
  - Stimulus: addr 0x1000, data 0xDEADBEEF, byteenable 4'b0011.
  - Response: bus outputs stable for 4 cycles; `data_valid` pulses once; `data_readdata` unchanged.
- Simultaneous requests after reset:
  - Response: data granted first, instr second.
  - Both pending again: data granted again, because `last_grant` alternates.
  - Each port gets exactly one valid.
- Watchdog:
  - Stimulus: `TIMEOUT`=4, `mem_waitrequest` held at 1.
  - Response: abort after 4 wait cycles; `bus_error`=1 and `data_valid`=1 in the same cycle; `data_readdata`=0; state IDLE.
- Reset during BUS_D with waitrequest=1:
  - Response: all `mem_*` outputs 0 the next cycle, no valid pulse; a fresh fetch afterwards completes normally.
- Read+write both set:
  - Stimulus: `data_read` and `data_write` both 1.
  - Response: only `mem_write`=1 is driven.
